capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Consumes the start/filter-select screen's outputs (`state_1_over`, 3-bit filter index) and the same left/middle/right buttons. Confirms the filter choice and runs a visible countdown. Issues a single-cycle capture strobe to the camera frame buffer and waits for its completion. It then offers retake/accept in a review state, and reports a latched filter index plus phase status to the display and filter pipeline.

## Interface
Parameters:
- `CLKS_PER_SEC`, 74_250_000, `clk_in` cycles per countdown step
- `COUNT_START`, 3, first countdown digit (1..3)
- `FRAME_TIMEOUT`, 2_475_000, max cycles to wait for `frame_done_in` (≈2 frames at 720p60)

Ports:
- `clk_in`  in  1  pixel clock; the only clock
- `rst_in`  in  1  synchronous, active-high reset
- `state_1_over`  in  1  level; high once the filter-select phase is active
- `select_in`  in  3  filter index 0..5 from the selector
- `middle_in`  in  1  button level; rising edge = confirm
- `left_in`  in  1  button level; rising edge = retake
- `right_in`  in  1  button level; rising edge = accept
- `frame_done_in`  in  1  frame buffer finished storing the captured frame
- `filter_out`  out  3  latched filter index
- `countdown_out`  out  2  current countdown digit (0 when not counting)
- `capture_out`  out  1  one-cycle capture strobe
- `state_out`  out  3  FSM state encoding (below)
- `review_out`  out  1  high in REVIEW
- `done_out`  out  1  high in DONE
- `error_out`  out  1  sticky frame-timeout flag

## Operation
- Edge detect: `prev_*` registers sample each button every cycle in all states, including IDLE. They reset to 0. `edge = in & ~prev`. A button held across a state change does not re-trigger.
- States (`state_out` encoding):
  - IDLE=0: when `state_1_over`=1, go to ARMED.
  - ARMED=1: on a middle edge, latch `filter_out <= (select_in>5) ? 0 : select_in`, load `countdown_out <= COUNT_START`, clear tick, and go to COUNTDOWN. Left and right edges are ignored.
  - COUNTDOWN=2: the tick counter increments each cycle. At `tick==CLKS_PER_SEC-1`: tick<=0.
    - If `countdown_out==1`: `countdown_out<=0` and go to CAPTURE.
    - Otherwise decrement `countdown_out`.
    - Buttons are ignored.
  - CAPTURE=3: `capture_out=1` this cycle only. Clear the timeout counter and go to WAIT_FRAME.
  - WAIT_FRAME=4: on `frame_done_in`=1, clear `error_out` and go to REVIEW. If instead the counter reaches `FRAME_TIMEOUT-1`, set `error_out` and go to ARMED. `frame_done_in` is ignored in every other state.
  - REVIEW=5:
    - Left edge alone: go to ARMED (retake; `filter_out` held).
    - Right edge alone: go to DONE.
    - Left and right edges in the same cycle: ignore both and stay.
  - DONE=6: terminal. `done_out`=1. Left only by `rst_in` or by `state_1_over` dropping.
- `state_1_over`=0 in any non-IDLE state forces IDLE on the next edge:
  - tick and timeout counters cleared, `countdown_out`=0;
  - `filter_out` and `error_out` held.
- `capture_out`, `review_out`, `done_out` are decoded from the registered state. `countdown_out` and `filter_out` are registers.
- Counter width is `$clog2` of its parameter. There is no wrap other than the defined reloads.

## Timing
- Reset values: state IDLE, `filter_out`=0, `countdown_out`=0, `capture_out`=0, `review_out`=0, `done_out`=0, `error_out`=0, counters 0, `prev_*`=0.
- Middle edge at cycle N puts the FSM in COUNTDOWN at N+1 (T).
- `countdown_out` holds each digit for exactly `CLKS_PER_SEC` cycles.
- `capture_out` is high at exactly T + `COUNT_START*CLKS_PER_SEC`, for one cycle.
- REVIEW is entered 1 cycle after `frame_done_in` is sampled high in WAIT_FRAME.
- Timeout: ARMED is entered `FRAME_TIMEOUT` cycles after entering WAIT_FRAME.
- `rst_in` mid-countdown or mid-wait returns to reset values on the next edge; no strobe is emitted.

## Test plan
All scenarios use `CLKS_PER_SEC`=4, `COUNT_START`=3, `FRAME_TIMEOUT`=8.

1. Full flow, select_in=4:
   - `state_1_over`↑, then middle pulse, then `frame_done_in` 3 cycles after the strobe, then right pulse.
   - Required: `filter_out`=4; `countdown_out` shows 3,3,3,3,2,2,2,2,1,1,1,1; one `capture_out` cycle; `review_out`=1; `done_out`=1.
2. Middle held high from IDLE through ARMED: no countdown starts. Release and press again: countdown starts.
3. select_in=7 at confirm: `filter_out`=0.
4. No `frame_done_in` after the strobe: ARMED 8 cycles after WAIT_FRAME entry, `error_out`=1. A later successful capture clears it.
5. In REVIEW, left+right in the same cycle: stays in REVIEW. Left alone: ARMED, `filter_out` unchanged.
6. Mid-countdown, `state_1_over`↓: IDLE next cycle, `countdown_out`=0, no `capture_out`. Repeat the same point with `rst_in`: all outputs return to reset values.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: confirms a filter choice, runs a countdown, strobes the
// frame buffer, waits for the stored frame and offers retake/accept.
module capture_sequencer #(
  parameter int CLKS_PER_SEC  = 74_250_000,
  parameter int COUNT_START   = 3,
  parameter int FRAME_TIMEOUT = 2_475_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       state_1_over,
  input  logic [2:0] select_in,
  input  logic       middle_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       frame_done_in,
  output logic [2:0] filter_out,
  output logic [1:0] countdown_out,
  output logic       capture_out,
  output logic [2:0] state_out,
  output logic       review_out,
  output logic       done_out,
  output logic       error_out
);

  localparam int TW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int OW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(CLKS_PER_SEC - 1);
  localparam logic [OW-1:0] WAIT_LAST   = OW'(FRAME_TIMEOUT - 1);
  localparam logic [1:0]    DIGIT_FIRST = 2'(COUNT_START);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARMED      = 3'd1,
    S_COUNTDOWN  = 3'd2,
    S_CAPTURE    = 3'd3,
    S_WAIT_FRAME = 3'd4,
    S_REVIEW     = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    filter_q, filter_d;
  logic [1:0]    count_q, count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] wait_q, wait_d;
  logic          error_q, error_d;
  logic          prev_mid_q, prev_left_q, prev_right_q;
  logic          mid_edge, left_edge, right_edge;

  // Buttons are sampled in every state so a held press never re-triggers.
  assign mid_edge   = middle_in & ~prev_mid_q;
  assign left_edge  = left_in   & ~prev_left_q;
  assign right_edge = right_in  & ~prev_right_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      filter_q     <= '0;
      count_q      <= '0;
      tick_q       <= '0;
      wait_q       <= '0;
      error_q      <= 1'b0;
      prev_mid_q   <= 1'b0;
      prev_left_q  <= 1'b0;
      prev_right_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      filter_q     <= filter_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      wait_q       <= wait_d;
      error_q      <= error_d;
      prev_mid_q   <= middle_in;
      prev_left_q  <= left_in;
      prev_right_q <= right_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    count_d  = count_q;
    tick_d   = tick_q;
    wait_d   = wait_q;
    error_d  = error_q;
    // Losing the filter-select phase aborts everything but keeps filter/error.
    if (state_q != S_IDLE && !state_1_over) begin
      state_d = S_IDLE;
      count_d = '0;
      tick_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_1_over) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (mid_edge) begin
            filter_d = (select_in > 3'd5) ? 3'd0 : select_in;
            count_d  = DIGIT_FIRST;
            tick_d   = '0;
            state_d  = S_COUNTDOWN;
          end
        end
        S_COUNTDOWN: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (count_q == 2'd1) begin
              count_d = '0;
              state_d = S_CAPTURE;
            end else begin
              count_d = count_q - 2'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          wait_d  = '0;
          state_d = S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (frame_done_in) begin
            error_d = 1'b0;
            state_d = S_REVIEW;
          end else if (wait_q == WAIT_LAST) begin
            error_d = 1'b1;
            wait_d  = '0;
            state_d = S_ARMED;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_REVIEW: begin
          // Simultaneous retake and accept is ambiguous, so neither wins.
          if (left_edge && !right_edge)      state_d = S_ARMED;
          else if (right_edge && !left_edge) state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign filter_out    = filter_q;
  assign countdown_out = count_q;
  assign error_out     = error_q;
  assign state_out     = state_q;
  assign capture_out   = (state_q == S_CAPTURE);
  assign review_out    = (state_q == S_REVIEW);
  assign done_out      = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: timeline model checked every cycle plus
// directed scenarios with literal expectations.
module tb_capture_sequencer;

  localparam int CPS = 4;
  localparam int CS  = 3;
  localparam int FT  = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       state_1_over = 1'b0;
  logic [2:0] select_in = 3'd0;
  logic       middle_in = 1'b0, left_in = 1'b0, right_in = 1'b0;
  logic       frame_done_in = 1'b0;
  logic [2:0] filter_out;
  logic [1:0] countdown_out;
  logic       capture_out;
  logic [2:0] state_out;
  logic       review_out, done_out, error_out;

  capture_sequencer #(.CLKS_PER_SEC(CPS), .COUNT_START(CS), .FRAME_TIMEOUT(FT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .state_1_over(state_1_over),
    .select_in(select_in), .middle_in(middle_in), .left_in(left_in),
    .right_in(right_in), .frame_done_in(frame_done_in),
    .filter_out(filter_out), .countdown_out(countdown_out),
    .capture_out(capture_out), .state_out(state_out),
    .review_out(review_out), .done_out(done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Timeline model: phases advance by elapsed-cycle arithmetic from entry times.
  int cyc = 0, m_nxt;
  int m_phase = 0, m_filter = 0, m_err = 0, m_t0 = 0, m_w0 = 0;
  bit m_pm = 0, m_pl = 0, m_pr = 0;
  bit e_m, e_l, e_r;

  always @(posedge clk_in) begin
    m_nxt = cyc + 1;
    e_m = middle_in && !m_pm;
    e_l = left_in && !m_pl;
    e_r = right_in && !m_pr;
    if (rst_in) begin
      m_phase = 0; m_filter = 0; m_err = 0;
    end else if (m_phase != 0 && !state_1_over) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (state_1_over) m_phase = 1;
        1: if (e_m) begin
             m_filter = (select_in > 5) ? 0 : int'(select_in);
             m_phase = 2; m_t0 = m_nxt;
           end
        2: if (m_nxt - m_t0 == CS * CPS) m_phase = 3;
        3: begin m_phase = 4; m_w0 = m_nxt; end
        4: if (frame_done_in) begin m_err = 0; m_phase = 5; end
           else if (m_nxt - m_w0 == FT) begin m_err = 1; m_phase = 1; end
        5: if (e_l && !e_r) m_phase = 1;
           else if (e_r && !e_l) m_phase = 6;
        default: ;
      endcase
    end
    m_pm = rst_in ? 1'b0 : middle_in;
    m_pl = rst_in ? 1'b0 : left_in;
    m_pr = rst_in ? 1'b0 : right_in;
    cyc = m_nxt;
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("m_state", int'(state_out), m_phase);
      check("m_filter", int'(filter_out), m_filter);
      check("m_countdown", int'(countdown_out),
            (m_phase == 2) ? CS - (cyc - m_t0) / CPS : 0);
      check("m_capture", int'(capture_out), int'(m_phase == 3));
      check("m_review", int'(review_out), int'(m_phase == 5));
      check("m_done", int'(done_out), int'(m_phase == 6));
      check("m_error", int'(error_out), m_err);
    end
  end

  task automatic cyc1();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, output int n);
    n = 0;
    while (int'(state_out) != s && n < budget) begin
      cyc1();
      n++;
    end
    if (int'(state_out) != s) check("wait_state_budget", int'(state_out), s);
  endtask

  int seq[$];
  int exp_seq[12] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1};
  int n;

  initial begin
    cyc1(); cyc1();
    rst_in = 1'b0;
    chk_en = 1'b1;
    check("reset_state", int'(state_out), 0);
    check("reset_filter", int'(filter_out), 0);

    // Full flow with select 4
    state_1_over = 1'b1; cyc1();
    check("armed", int'(state_out), 1);
    select_in = 3'd4; middle_in = 1'b1; cyc1(); middle_in = 1'b0;
    check("cd_start", int'(state_out), 2);
    seq.delete(); n = 0;
    while (!capture_out && n < 40) begin
      if (countdown_out != 0) seq.push_back(int'(countdown_out));
      cyc1(); n++;
    end
    check("strobe_seen", int'(capture_out), 1);
    check("strobe_delay", n, 12);
    check("seq_len", seq.size(), 12);
    foreach (seq[i]) if (i < 12) check("digit", seq[i], exp_seq[i]);
    cyc1();
    check("strobe_one_cycle", int'(capture_out), 0);
    check("wait_frame", int'(state_out), 4);
    cyc1(); frame_done_in = 1'b1; cyc1(); frame_done_in = 1'b0;
    check("review", int'(review_out), 1);
    right_in = 1'b1; cyc1(); right_in = 1'b0;
    check("done", int'(done_out), 1);
    check("filter4", int'(filter_out), 4);
    repeat (3) cyc1();
    check("done_hold", int'(state_out), 6);

    // Middle held from IDLE into ARMED must not start a countdown
    state_1_over = 1'b0; middle_in = 1'b1; cyc1();
    check("done_to_idle", int'(state_out), 0);
    cyc1(); state_1_over = 1'b1; cyc1();
    repeat (3) cyc1();
    check("held_mid_no_start", int'(state_out), 1);
    middle_in = 1'b0; cyc1();
    middle_in = 1'b1; cyc1(); middle_in = 1'b0;
    check("repress_starts", int'(state_out), 2);
    check("repress_digit", int'(countdown_out), 3);

    // Abort mid-countdown by dropping state_1_over
    repeat (5) cyc1();
    check("mid_cd_digit", int'(countdown_out), 2);
    state_1_over = 1'b0; cyc1();
    check("abort_idle", int'(state_out), 0);
    check("abort_cd0", int'(countdown_out), 0);
    repeat (10) cyc1();
    check("abort_filter_held", int'(filter_out), 4);
    state_1_over = 1'b1; cyc1();

    // Out-of-range select clamps to 0, then frame timeout
    select_in = 3'd7; middle_in = 1'b1; cyc1(); middle_in = 1'b0;
    check("sel7_clamp", int'(filter_out), 0);
    wait_state(4, 40, n);
    n = 0;
    while (int'(state_out) == 4 && n < 20) begin cyc1(); n++; end
    check("timeout_len", n, 8);
    check("timeout_armed", int'(state_out), 1);
    check("timeout_error", int'(error_out), 1);

    // Successful capture clears the error
    select_in = 3'd2; middle_in = 1'b1; cyc1(); middle_in = 1'b0;
    wait_state(4, 40, n);
    frame_done_in = 1'b1; cyc1(); frame_done_in = 1'b0;
    check("review2", int'(review_out), 1);
    check("error_cleared", int'(error_out), 0);

    // Simultaneous left+right ignored; left alone retakes
    left_in = 1'b1; right_in = 1'b1; cyc1(); left_in = 1'b0; right_in = 1'b0;
    check("both_stay", int'(state_out), 5);
    cyc1(); left_in = 1'b1; cyc1(); left_in = 1'b0;
    check("retake_armed", int'(state_out), 1);
    check("retake_filter", int'(filter_out), 2);

    // Reset mid-countdown
    select_in = 3'd5; middle_in = 1'b1; cyc1(); middle_in = 1'b0;
    check("filter5", int'(filter_out), 5);
    repeat (6) cyc1();
    rst_in = 1'b1; cyc1(); rst_in = 1'b0;
    check("rst_state", int'(state_out), 0);
    check("rst_filter", int'(filter_out), 0);
    check("rst_cd", int'(countdown_out), 0);
    check("rst_capture", int'(capture_out), 0);
    check("rst_error", int'(error_out), 0);
    repeat (20) cyc1();
    check("post_rst_armed", int'(state_out), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
